// File: rtl/scara_stepper_pkg.sv
// Shared types and default timing for the SCARA stepper pulse executor.
package scara_stepper_pkg;
  localparam int STEP_W          = 9;
  localparam int NUM_AXES        = 2;
  localparam int DEF_STEP_PERIOD = 50;
  localparam int DEF_PULSE_WIDTH = 10;
  localparam int DEF_DIR_SETUP   = 4;
  localparam int DEF_POS_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIR_SETUP,
    ST_PULSE_HIGH,
    ST_PULSE_LOW,
    ST_DONE
  } exec_state_e;

  // Timer only ever holds a load value of (duration - 1), so log2 of the longest duration suffices.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/step_axis_channel.sv
// One stepper axis: remaining-step counter, DIR latch, signed position and STEP gating.
module step_axis_channel
  import scara_stepper_pkg::*;
#(
  parameter int POS_W = DEF_POS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [STEP_W-1:0] steps,
  input  logic              dir,
  input  logic              pulse_start,
  input  logic              pulse_active,
  output logic              step_out,
  output logic              dir_out,
  output logic              rem_nz,
  output logic [POS_W-1:0]  position
);
  logic [STEP_W-1:0] rem;

  assign rem_nz = |rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      dir_out  <= 1'b0;
      position <= '0;
      step_out <= 1'b0;
    end else begin
      if (load) begin
        rem     <= steps;
        dir_out <= dir;
      end else if (pulse_start && rem_nz) begin
        rem      <= rem - STEP_W'(1);
        position <= dir_out ? position + POS_W'(1) : position - POS_W'(1);
      end
      // Whether this axis pulses is decided once at PulseHigh entry and held for the width.
      step_out <= pulse_active & (pulse_start ? rem_nz : step_out);
    end
  end
endmodule

// File: rtl/stepper_pulse_executor.sv
// Accepts step commands from the calculator and drives STEP/DIR to two stepper drivers.
module stepper_pulse_executor
  import scara_stepper_pkg::*;
#(
  parameter int STEP_PERIOD = DEF_STEP_PERIOD,
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int DIR_SETUP   = DEF_DIR_SETUP,
  parameter int POS_W       = DEF_POS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STEP_W-1:0] steps1,
  input  logic [STEP_W-1:0] steps2,
  input  logic              dir1,
  input  logic              dir2,
  input  logic              dataReady,
  output logic              step1_out,
  output logic              step2_out,
  output logic              dir1_out,
  output logic              dir2_out,
  output logic              busy,
  output logic              done,
  output logic              cmd_dropped,
  output logic [POS_W-1:0]  position1,
  output logic [POS_W-1:0]  position2
);
  localparam int CNT_W = timer_width(STEP_PERIOD, DIR_SETUP);

  exec_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic dr_prev, rise, load, pulse_start, pulse_active, drop_q;

  logic [NUM_AXES-1:0][STEP_W-1:0] steps_in;
  logic [NUM_AXES-1:0][POS_W-1:0]  pos_q;
  logic [NUM_AXES-1:0]             dir_in, step_q, dir_q, rem_nz;

  assign steps_in = {steps2, steps1};
  assign dir_in   = {dir2, dir1};
  assign rise     = dataReady & ~dr_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dr_prev <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dr_prev <= dataReady;
      drop_q  <= rise && (state != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          load = 1'b1;
          if (steps1 == '0 && steps2 == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_DIR_SETUP;
            cnt_nxt   = CNT_W'(DIR_SETUP - 1);
          end
        end
      end
      ST_DIR_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE_HIGH;
          cnt_nxt   = CNT_W'(PULSE_WIDTH - 1);
        end
      end
      ST_PULSE_HIGH: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE_LOW;
          cnt_nxt   = CNT_W'(STEP_PERIOD - PULSE_WIDTH - 1);
        end
      end
      ST_PULSE_LOW: begin
        // rem counters already reflect the pulse just issued.
        if (cnt == '0) begin
          if (|rem_nz) begin
            state_nxt = ST_PULSE_HIGH;
            cnt_nxt   = CNT_W'(PULSE_WIDTH - 1);
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign pulse_active = (state_nxt == ST_PULSE_HIGH);
  assign pulse_start  = pulse_active && (state != ST_PULSE_HIGH);

  for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
    step_axis_channel #(.POS_W(POS_W)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .steps        (steps_in[g]),
      .dir          (dir_in[g]),
      .pulse_start  (pulse_start),
      .pulse_active (pulse_active),
      .step_out     (step_q[g]),
      .dir_out      (dir_q[g]),
      .rem_nz       (rem_nz[g]),
      .position     (pos_q[g])
    );
  end

  assign step1_out   = step_q[0];
  assign step2_out   = step_q[1];
  assign dir1_out    = dir_q[0];
  assign dir2_out    = dir_q[1];
  assign position1   = pos_q[0];
  assign position2   = pos_q[1];
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign cmd_dropped = drop_q;
endmodule

// File: tb/tb_stepper_pulse_executor.sv
// Scoreboard bench: driver predicts each move from timing rules, monitor checks waveforms and completion.
module tb_stepper_pulse_executor;
  localparam int SP = 50;
  localparam int PW = 10;
  localparam int DS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [8:0] steps1 = '0, steps2 = '0;
  logic dir1 = 1'b0, dir2 = 1'b0, dataReady = 1'b0;
  logic step1_out, step2_out, dir1_out, dir2_out, busy, done, cmd_dropped;
  logic [15:0] position1, position2;

  stepper_pulse_executor #(.STEP_PERIOD(SP), .PULSE_WIDTH(PW), .DIR_SETUP(DS), .POS_W(16)) dut (
    .clk(clk), .reset(reset), .steps1(steps1), .steps2(steps2), .dir1(dir1), .dir2(dir2),
    .dataReady(dataReady), .step1_out(step1_out), .step2_out(step2_out), .dir1_out(dir1_out),
    .dir2_out(dir2_out), .busy(busy), .done(done), .cmd_dropped(cmd_dropped),
    .position1(position1), .position2(position2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int a; int first; int done_c;
    int n1; int n2; bit d1; bit d2;
    logic [15:0] p1; logic [15:0] p2;
  } exp_t;

  exp_t sb[$];
  int npass = 0, ntot = 0;
  int model_done = -1, exp_drops = 0, drops_seen = 0;
  logic [15:0] mp1 = '0, mp2 = '0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_eq(input string name, input longint act, input longint exp);
    check(name, act == exp, act, exp);
  endtask

  // Monitor
  bit ps[2], pd[2];
  int npul[2], lrise[2], dchg[2] = '{-1000, -1000};
  int busy_cnt = 0;

  always @(negedge clk) begin
    bit st[2], dv[2];
    exp_t e;
    st[0] = step1_out; st[1] = step2_out;
    dv[0] = dir1_out;  dv[1] = dir2_out;
    if (reset) begin
      for (int ax = 0; ax < 2; ax++) begin
        ps[ax] = 1'b0; pd[ax] = dv[ax]; npul[ax] = 0;
      end
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (cmd_dropped) drops_seen++;
      for (int ax = 0; ax < 2; ax++) begin
        if (dv[ax] != pd[ax]) begin
          check("dir_change_while_step", !st[ax] && !ps[ax], st[ax] | ps[ax], 0);
          dchg[ax] = cyc;
        end
        if (st[ax] && !ps[ax]) begin
          npul[ax]++;
          if (npul[ax] == 1) begin
            if (sb.size() == 0) check("step_without_move", 1'b0, 1, 0);
            else begin
              chk_eq("first_step_edge", cyc, sb[0].first);
              chk_eq("dir_value", dv[ax], (ax == 0) ? sb[0].d1 : sb[0].d2);
            end
            check("dir_setup_gap", cyc - dchg[ax] >= DS, cyc - dchg[ax], DS);
          end else begin
            chk_eq("step_period", cyc - lrise[ax], SP);
          end
          lrise[ax] = cyc;
        end
        if (!st[ax] && ps[ax]) chk_eq("pulse_width", cyc - lrise[ax], PW);
        ps[ax] = st[ax]; pd[ax] = dv[ax];
      end
      if (done) begin
        if (sb.size() == 0) check("done_without_move", 1'b0, 1, 0);
        else begin
          e = sb.pop_front();
          chk_eq("done_cycle", cyc, e.done_c);
          chk_eq("pulses_axis1", npul[0], e.n1);
          chk_eq("pulses_axis2", npul[1], e.n2);
          chk_eq("position1", $signed(position1), $signed(e.p1));
          chk_eq("position2", $signed(position2), $signed(e.p2));
          chk_eq("busy_cycles", busy_cnt, e.done_c - e.a);
        end
        npul[0] = 0; npul[1] = 0; busy_cnt = 0;
      end
    end
  end

  // Driver: raise dataReady for 'hold' cycles; the model decides accept vs drop.
  task automatic issue(input int s1, input bit d1, input int s2, input bit d2, input int hold,
                       output int a);
    exp_t e;
    int mx;
    @(posedge clk); #1;
    steps1 = 9'(s1); steps2 = 9'(s2); dir1 = d1; dir2 = d2;
    dataReady = 1'b1;
    a = cyc;
    if (a > model_done) begin
      mx = (s1 > s2) ? s1 : s2;
      e.a = a; e.first = a + 1 + DS;
      e.done_c = (mx == 0) ? a + 1 : a + 1 + DS + mx * SP;
      e.n1 = s1; e.n2 = s2; e.d1 = d1; e.d2 = d2;
      mp1 = d1 ? mp1 + 16'(s1) : mp1 - 16'(s1);
      mp2 = d2 ? mp2 + 16'(s2) : mp2 - 16'(s2);
      e.p1 = mp1; e.p2 = mp2;
      sb.push_back(e);
      model_done = e.done_c;
    end else begin
      exp_drops++;
    end
    repeat (hold) @(posedge clk);
    #1 dataReady = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("move_timeout", sb.size() == 0, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int a, s1, s2, dly;
    #2;
    chk_eq("reset_step1", step1_out, 0);
    chk_eq("reset_busy", busy, 0);
    chk_eq("reset_done", done, 0);
    chk_eq("reset_pos1", position1, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    issue(3, 1, 0, 0, 1, a);          // single axis
    wait_idle();
    issue(2, 0, 5, 1, 1, a);          // dir reversal on axis 1, unequal lengths
    wait_idle();
    issue(0, 0, 0, 1, 1, a);          // zero/zero
    wait_idle();
    issue(3, 1, 2, 0, 1, a);          // second edge mid-move must be dropped
    repeat (40) @(posedge clk);
    issue(7, 0, 7, 1, 1, a);
    wait_idle();
    issue(1, 1, 1, 1, 200, a);        // level held high
    wait_idle();

    issue(4, 1, 4, 0, 1, a);          // reset in 2nd PulseHigh
    while (cyc < a + 1 + DS + SP + 3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk_eq("midreset_step1", step1_out, 0);
    chk_eq("midreset_step2", step2_out, 0);
    chk_eq("midreset_pos1", position1, 0);
    chk_eq("midreset_pos2", position2, 0);
    chk_eq("midreset_busy", busy, 0);
    sb.delete();
    mp1 = '0; mp2 = '0; model_done = -1;
    @(posedge clk); #1 reset = 1'b0;
    issue(2, 0, 3, 1, 1, a);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      s1 = $urandom_range(0, 5);
      s2 = $urandom_range(0, 5);
      issue(s1, 1'($urandom), s2, 1'($urandom), $urandom_range(1, 3), a);
      if ($urandom_range(0, 2) == 0) begin
        dly = $urandom_range(0, 60);
        repeat (dly) @(posedge clk);
        issue($urandom_range(0, 5), 1'($urandom), $urandom_range(0, 5), 1'($urandom), 1, a);
      end
      wait_idle();
    end

    repeat (5) @(posedge clk);
    chk_eq("cmd_dropped_count", drops_seen, exp_drops);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
